ram_arbiter_2req: RTL and testbench

- Two-requester round-robin arbiter and sequencer for one single-port 128x32 synchronous-write, asynchronous-read RAM.
- Each requester issues single-word read or write commands with a req/ack handshake. The block registers the winning command, drives the RAM port for exactly one cycle, and returns read data one cycle later.
- Sits between the two memory clients and the RAM instance. It is the only driver of the RAM port.

---
 rtl/ram_arb_pkg.sv | 41 ++++
 rtl/ram_arbiter_2req_rr_arb2.sv | 48 ++++
 rtl/ram_arbiter_2req.sv | 192 +++++++++++++++++++
 tb/tb_ram_arbiter_2req.sv | 406 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ram_arb_pkg
// Description : Shared types and constants for the two-requester RAM
//               arbiter: FSM state encoding, requester ids and the
//               round-robin pick rule used by rr_arb2.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package ram_arb_pkg;

   // Sequencer states. ACCESS lasts exactly one cycle.
   typedef enum logic [0:0] {
      IDLE   = 1'b0,
      ACCESS = 1'b1
   } state_e;

   // Requester ids, as carried in the winner/cmd id signals.
   localparam logic REQ0 = 1'b0;
   localparam logic REQ1 = 1'b1;

   // Round-robin pick between two requesters.
   // A lone requester wins outright; on contention the requester that did
   // not win last time is chosen. With no request the result is REQ0, which
   // callers must ignore (they only use it when a request is present).
   function automatic logic rr_pick(input logic r0,
                                    input logic r1,
                                    input logic last_gnt);
      logic pick;
      if (r0 && r1) begin
         pick = ~last_gnt;
      end else if (r1) begin
         pick = REQ1;
      end else begin
         pick = REQ0;
      end
      return pick;
   endfunction

endpackage : ram_arb_pkg
`default_nettype wire

// File: rtl/ram_arbiter_2req_rr_arb2.sv
`default_nettype none
// ============================================================================
// Module      : rr_arb2
// Description : Two-way round-robin arbiter. Holds the last-granted id and
//               presents the current winner combinationally. The history
//               register moves to the winner only when the caller strobes
//               advance_i, i.e. when a command is actually accepted.
// Ports       : clk        - system clock
//               reset      - synchronous active-high reset
//               req0_i     - requester 0 request
//               req1_i     - requester 1 request
//               advance_i  - a grant is being taken this cycle
//               gnt_id_o   - id of the requester that wins this cycle
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arb2
   import ram_arb_pkg::*;
(
   input  logic clk,
   input  logic reset,
   input  logic req0_i,
   input  logic req1_i,
   input  logic advance_i,
   output logic gnt_id_o
);

   logic last_gnt_q;
   logic last_gnt_d;

   always_comb begin
      gnt_id_o   = rr_pick(req0_i, req1_i, last_gnt_q);
      last_gnt_d = last_gnt_q;
      if (advance_i) begin
         last_gnt_d = gnt_id_o;
      end
   end

   // Reset to REQ1 so that requester 0 wins the first contention.
   always_ff @(posedge clk) begin
      if (reset) begin
         last_gnt_q <= REQ1;
      end else begin
         last_gnt_q <= last_gnt_d;
      end
   end

endmodule : rr_arb2
`default_nettype wire

// File: rtl/ram_arbiter_2req.sv
`default_nettype none
// ============================================================================
// Module      : ram_arbiter_2req
// Description : Round-robin arbiter and sequencer placing two single-word
//               requesters onto one single-port RAM (synchronous write,
//               asynchronous read). A winning command is registered in IDLE,
//               drives the RAM port for the single ACCESS cycle, and read
//               data is returned in the cycle after ACCESS.
// Ports       : clk, reset           - clock, synchronous active-high reset
//               req0/we0/addr0/wdata0 - requester 0 command (held until ack0)
//               ack0                  - requester 0 command executed this cycle
//               rdata0/rvalid0        - requester 0 read return
//               req1 ... rvalid1      - same for requester 1
//               ram_we/ram_address/ram_d - RAM port drive
//               ram_q                 - RAM combinational read data
// Revision    : 1.0 - initial release
// ============================================================================
module ram_arbiter_2req
   import ram_arb_pkg::*;
#(
   parameter int Data_width = 32,
   parameter int Addr_width = 7
) (
   input  logic                  clk,
   input  logic                  reset,
   // requester 0
   input  logic                  req0,
   input  logic                  we0,
   input  logic [Addr_width-1:0] addr0,
   input  logic [Data_width-1:0] wdata0,
   output logic                  ack0,
   output logic [Data_width-1:0] rdata0,
   output logic                  rvalid0,
   // requester 1
   input  logic                  req1,
   input  logic                  we1,
   input  logic [Addr_width-1:0] addr1,
   input  logic [Data_width-1:0] wdata1,
   output logic                  ack1,
   output logic [Data_width-1:0] rdata1,
   output logic                  rvalid1,
   // RAM port
   output logic                  ram_we,
   output logic [Addr_width-1:0] ram_address,
   output logic [Data_width-1:0] ram_d,
   input  logic [Data_width-1:0] ram_q
);

   // ------------------------------------------------------------------
   // State and command registers
   // ------------------------------------------------------------------
   state_e                state_q;
   state_e                state_d;
   logic                  cmd_id_q;
   logic                  cmd_id_d;
   logic                  cmd_we_q;
   logic                  cmd_we_d;
   // The cmd address/data registers drive the RAM port directly, so the
   // port holds its last value outside ACCESS without extra registers.
   logic [Addr_width-1:0] cmd_addr_q;
   logic [Addr_width-1:0] cmd_addr_d;
   logic [Data_width-1:0] cmd_wdata_q;
   logic [Data_width-1:0] cmd_wdata_d;

   logic [Data_width-1:0] rdata0_q;
   logic [Data_width-1:0] rdata0_d;
   logic [Data_width-1:0] rdata1_q;
   logic [Data_width-1:0] rdata1_d;
   logic                  rvalid0_q;
   logic                  rvalid0_d;
   logic                  rvalid1_q;
   logic                  rvalid1_d;

   logic                  any_req;
   logic                  take_cmd;
   logic                  gnt_id;
   logic                  access_live;

   assign any_req  = req0 | req1;
   // Requests are only looked at in IDLE; a req still high during its own
   // ACCESS cycle is not re-sampled.
   assign take_cmd = (state_q == IDLE) && any_req;

   // ------------------------------------------------------------------
   // Round-robin winner selection
   // ------------------------------------------------------------------
   rr_arb2 u_rr_arb2 (
      .clk       (clk),
      .reset     (reset),
      .req0_i    (req0),
      .req1_i    (req1),
      .advance_i (take_cmd),
      .gnt_id_o  (gnt_id)
   );

   // ------------------------------------------------------------------
   // Next-state, command capture and read capture
   // ------------------------------------------------------------------
   always_comb begin
      state_d     = state_q;
      cmd_id_d    = cmd_id_q;
      cmd_we_d    = cmd_we_q;
      cmd_addr_d  = cmd_addr_q;
      cmd_wdata_d = cmd_wdata_q;
      rdata0_d    = rdata0_q;
      rdata1_d    = rdata1_q;
      rvalid0_d   = 1'b0;
      rvalid1_d   = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (any_req) begin
               state_d  = ACCESS;
               cmd_id_d = gnt_id;
               if (gnt_id == REQ1) begin
                  cmd_we_d    = we1;
                  cmd_addr_d  = addr1;
                  cmd_wdata_d = wdata1;
               end else begin
                  cmd_we_d    = we0;
                  cmd_addr_d  = addr0;
                  cmd_wdata_d = wdata0;
               end
            end
         end

         ACCESS: begin
            state_d = IDLE;
            // The RAM is read asynchronously, so ram_q already reflects
            // cmd_addr during ACCESS and is captured on the closing edge.
            if (!cmd_we_q) begin
               if (cmd_id_q == REQ1) begin
                  rdata1_d  = ram_q;
                  rvalid1_d = 1'b1;
               end else begin
                  rdata0_d  = ram_q;
                  rvalid0_d = 1'b1;
               end
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         cmd_id_q    <= REQ0;
         cmd_we_q    <= 1'b0;
         cmd_addr_q  <= '0;
         cmd_wdata_q <= '0;
         rdata0_q    <= '0;
         rdata1_q    <= '0;
         rvalid0_q   <= 1'b0;
         rvalid1_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         cmd_id_q    <= cmd_id_d;
         cmd_we_q    <= cmd_we_d;
         cmd_addr_q  <= cmd_addr_d;
         cmd_wdata_q <= cmd_wdata_d;
         rdata0_q    <= rdata0_d;
         rdata1_q    <= rdata1_d;
         rvalid0_q   <= rvalid0_d;
         rvalid1_q   <= rvalid1_d;
      end
   end

   // ------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------
   // Reset is folded in combinationally so that a reset arriving during
   // ACCESS blocks the RAM write and the ack in that same cycle; the
   // command is then dropped by the register reset.
   assign access_live = (state_q == ACCESS) && !reset;

   assign ack0        = access_live && (cmd_id_q == REQ0);
   assign ack1        = access_live && (cmd_id_q == REQ1);
   assign ram_we      = access_live && cmd_we_q;
   assign ram_address = cmd_addr_q;
   assign ram_d       = cmd_wdata_q;

   assign rdata0      = rdata0_q;
   assign rdata1      = rdata1_q;
   assign rvalid0     = rvalid0_q;
   assign rvalid1     = rvalid1_q;

endmodule : ram_arbiter_2req
`default_nettype wire

// File: tb/tb_ram_arbiter_2req.sv
`default_nettype none
// ============================================================================
// Module      : tb_ram_arbiter_2req
// Description : Self-checking bench for ram_arbiter_2req. Two command queues
//               act as the requesters; a transaction-level model (memory
//               array, last winner, pending read return) predicts acks,
//               read returns and the RAM port for every cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ram_arbiter_2req;

   localparam int DW    = 32;
   localparam int AW    = 7;
   localparam int DEPTH = 1 << AW;

   typedef struct {
      bit          we;
      bit [AW-1:0] addr;
      bit [DW-1:0] data;
   } cmd_t;

   logic          clk    = 1'b0;
   logic          reset  = 1'b1;
   logic          req0   = 1'b0;
   logic          we0    = 1'b0;
   logic [AW-1:0] addr0  = '0;
   logic [DW-1:0] wdata0 = '0;
   logic          req1   = 1'b0;
   logic          we1    = 1'b0;
   logic [AW-1:0] addr1  = '0;
   logic [DW-1:0] wdata1 = '0;
   logic          ack0;
   logic          ack1;
   logic          rvalid0;
   logic          rvalid1;
   logic [DW-1:0] rdata0;
   logic [DW-1:0] rdata1;
   logic          ram_we;
   logic [AW-1:0] ram_address;
   logic [DW-1:0] ram_d;
   logic [DW-1:0] ram_q;

   always #5 clk = ~clk;

   ram_arbiter_2req #(.Data_width(DW), .Addr_width(AW)) dut (
      .clk(clk), .reset(reset),
      .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
      .ack0(ack0), .rdata0(rdata0), .rvalid0(rvalid0),
      .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
      .ack1(ack1), .rdata1(rdata1), .rvalid1(rvalid1),
      .ram_we(ram_we), .ram_address(ram_address), .ram_d(ram_d), .ram_q(ram_q)
   );

   // Environment RAM: synchronous write, asynchronous read, cleared at start.
   logic          ram_init = 1'b1;
   logic [DW-1:0] ram [0:DEPTH-1];
   always @(posedge clk) begin
      if (ram_init) begin
         for (int i = 0; i < DEPTH; i++) ram[i] <= '0;
      end else if (ram_we === 1'b1) begin
         ram[ram_address] <= ram_d;
      end
   end
   assign ram_q = ram[ram_address];

   // ------------------------------------------------------------------
   // Reference model (transaction level)
   // ------------------------------------------------------------------
   bit [DW-1:0] mmem [0:DEPTH-1];
   bit          m_access = 1'b0;   // an access occupies the RAM this cycle
   bit          m_id     = 1'b0;
   bit          m_we     = 1'b0;
   bit [AW-1:0] m_addr   = '0;
   bit [DW-1:0] m_wdata  = '0;
   bit          m_last   = 1'b1;   // id of the last granted requester
   bit          m_rv0    = 1'b0;
   bit          m_rv1    = 1'b0;
   bit [DW-1:0] m_rd0    = '0;
   bit [DW-1:0] m_rd1    = '0;
   bit          exp_ack0 = 1'b0;
   bit          exp_ack1 = 1'b0;
   bit          exp_we   = 1'b0;
   bit          started  = 1'b0;
   bit          rst_req  = 1'b1;
   cmd_t        q0[$];
   cmd_t        q1[$];
   int          n_total  = 0;
   int          n_bad    = 0;

   function automatic cmd_t mk(bit we, bit [AW-1:0] addr, bit [DW-1:0] data);
      cmd_t c;
      c.we = we; c.addr = addr; c.data = data;
      return c;
   endfunction

   function automatic cmd_t mk_rand();
      cmd_t c;
      c.we   = ($urandom_range(0, 1) == 1);
      c.addr = ($urandom_range(0, 3) == 0) ? 7'h7F : AW'($urandom_range(0, 7));
      c.data = $urandom;
      return c;
   endfunction

   // Outcome of the clock edge closing the current cycle.
   task automatic model_update();
      bit w;
      if (exp_ack0) void'(q0.pop_front());
      if (exp_ack1) void'(q1.pop_front());
      if (reset) begin
         m_access = 1'b0; m_last = 1'b1;
         m_rv0 = 1'b0; m_rv1 = 1'b0; m_rd0 = '0; m_rd1 = '0;
         m_addr = '0; m_wdata = '0;
      end else begin
         m_rv0 = 1'b0; m_rv1 = 1'b0;
         if (m_access) begin
            if (m_we) mmem[m_addr] = m_wdata;
            else if (m_id) begin m_rv1 = 1'b1; m_rd1 = mmem[m_addr]; end
            else begin m_rv0 = 1'b1; m_rd0 = mmem[m_addr]; end
            m_access = 1'b0;
         end else if (req0 || req1) begin
            w        = (req0 && req1) ? !m_last : req1;
            m_last   = w;
            m_access = 1'b1;
            m_id     = w;
            m_we     = w ? we1 : we0;
            m_addr   = w ? addr1 : addr0;
            m_wdata  = w ? wdata1 : wdata0;
         end
      end
   endtask

   // One clock cycle: inputs driven just after the rising edge, outputs
   // left for the caller to sample at the falling edge.
   task automatic step();
      if (started) model_update();
      started = 1'b1;
      @(posedge clk);
      #1;
      reset = rst_req;
      if (q0.size() > 0) begin
         req0 = 1'b1; we0 = q0[0].we; addr0 = q0[0].addr; wdata0 = q0[0].data;
      end else begin
         req0 = 1'b0; we0 = 1'b0; addr0 = '0; wdata0 = '0;
      end
      if (q1.size() > 0) begin
         req1 = 1'b1; we1 = q1[0].we; addr1 = q1[0].addr; wdata1 = q1[0].data;
      end else begin
         req1 = 1'b0; we1 = 1'b0; addr1 = '0; wdata1 = '0;
      end
      exp_ack0 = m_access && !m_id && !rst_req;
      exp_ack1 = m_access &&  m_id && !rst_req;
      exp_we   = m_access &&  m_we && !rst_req;
      @(negedge clk);
   endtask

   task automatic drain();
      int n = 0;
      while ((q0.size() > 0 || q1.size() > 0 || m_access || m_rv0 || m_rv1) && n < 40) begin
         step();
         n++;
      end
      step();
      n_total++;
      if (n >= 40) begin
         n_bad++;
         $display("FAIL drain_timeout cycles=%0d limit=40", n);
      end
   endtask

   // ------------------------------------------------------------------
   // Scenarios
   // ------------------------------------------------------------------
   task automatic test_reset();
      rst_req = 1'b1;
      repeat (3) step();
      ram_init = 1'b0;
      n_total++;
      if ({ack0, ack1, rvalid0, rvalid1, ram_we} !== 5'b0) begin
         n_bad++; $display("FAIL reset_ctl got=%b want=00000", {ack0, ack1, rvalid0, rvalid1, ram_we});
      end
      n_total++;
      if (ram_address !== '0 || ram_d !== '0) begin
         n_bad++; $display("FAIL reset_port got=%h/%h want=0/0", ram_address, ram_d);
      end
      n_total++;
      if (rdata0 !== '0 || rdata1 !== '0) begin
         n_bad++; $display("FAIL reset_rdata got=%h/%h want=0/0", rdata0, rdata1);
      end
   endtask

   task automatic test_reset_mid_access();
      int n_rv = 0;
      rst_req = 1'b0;
      step();
      q0.push_back(mk(1'b1, 7'h10, 32'hDEADBEEF));
      step();
      rst_req = 1'b1;
      step();
      n_total++;
      if (ram_we !== 1'b0 || ack0 !== 1'b0) begin
         n_bad++; $display("FAIL rstacc_block got we=%b ack0=%b want 0 0", ram_we, ack0);
      end
      n_total++;
      if (rvalid0 !== 1'b0 || ack1 !== 1'b0) begin
         n_bad++; $display("FAIL rstacc_quiet got rv0=%b ack1=%b want 0 0", rvalid0, ack1);
      end
      q0.delete();
      rst_req = 1'b0;
      step();
      step();
      q0.push_back(mk(1'b0, 7'h10, 32'h0));
      for (int i = 0; i < 6; i++) begin
         step();
         n_total++;
         if ({ack0, ack1, rvalid0, rvalid1, ram_we} !== {exp_ack0, exp_ack1, m_rv0, m_rv1, exp_we}) begin
            n_bad++; $display("FAIL rstacc_ctl cyc=%0d got=%b want=%b", i,
               {ack0, ack1, rvalid0, rvalid1, ram_we}, {exp_ack0, exp_ack1, m_rv0, m_rv1, exp_we});
         end
         if (rvalid0 === 1'b1) n_rv++;
         if (m_rv0) begin
            n_total++;
            if (rdata0 === 32'hDEADBEEF || rdata0 !== m_rd0) begin
               n_bad++; $display("FAIL rstacc_data got=%h want=%h", rdata0, m_rd0);
            end
         end
      end
      n_total++;
      if (n_rv !== 1) begin
         n_bad++; $display("FAIL rstacc_rvcount got=%0d want=1", n_rv);
      end
      drain();
   endtask

   task automatic test_write_read();
      int          ack_cyc[$];
      int          rv_cyc = -1;
      logic [DW-1:0] rd = '0;
      q0.push_back(mk(1'b1, 7'h05, 32'h12345678));
      q0.push_back(mk(1'b0, 7'h05, 32'h0));
      for (int i = 0; i < 8; i++) begin
         step();
         n_total++;
         if ({ack0, ack1, rvalid0, rvalid1, ram_we} !== {exp_ack0, exp_ack1, m_rv0, m_rv1, exp_we}) begin
            n_bad++; $display("FAIL wr_rd_ctl cyc=%0d got=%b want=%b", i,
               {ack0, ack1, rvalid0, rvalid1, ram_we}, {exp_ack0, exp_ack1, m_rv0, m_rv1, exp_we});
         end
         if (ack0 === 1'b1) ack_cyc.push_back(i);
         if (rvalid0 === 1'b1) begin rv_cyc = i; rd = rdata0; end
      end
      n_total++;
      if (ack_cyc.size() != 2 || ack_cyc[0] != 1 || ack_cyc[1] != 3) begin
         n_bad++; $display("FAIL wr_rd_acktime got n=%0d first=%0d want n=2 at 1,3", ack_cyc.size(),
            (ack_cyc.size() > 0) ? ack_cyc[0] : -1);
      end
      n_total++;
      if (rv_cyc != 4) begin
         n_bad++; $display("FAIL wr_rd_rvtime got=%0d want=4", rv_cyc);
      end
      n_total++;
      if (rd !== 32'h12345678) begin
         n_bad++; $display("FAIL wr_rd_data got=%h want=12345678", rd);
      end
      drain();
   endtask

   task automatic test_contention();
      int order[$];
      int at[$];
      rst_req = 1'b1;
      step();
      for (int k = 0; k < 5; k++) begin
         q0.push_back(mk(1'b0, 7'h01, 32'h0));
         q1.push_back(mk(1'b0, 7'h02, 32'h0));
      end
      rst_req = 1'b0;
      for (int i = 0; i < 18; i++) begin
         step();
         n_total++;
         if ({ack0, ack1, rvalid0, rvalid1, ram_we} !== {exp_ack0, exp_ack1, m_rv0, m_rv1, exp_we}) begin
            n_bad++; $display("FAIL contend_ctl cyc=%0d got=%b want=%b", i,
               {ack0, ack1, rvalid0, rvalid1, ram_we}, {exp_ack0, exp_ack1, m_rv0, m_rv1, exp_we});
         end
         if (ack0 === 1'b1) begin order.push_back(0); at.push_back(i); end
         if (ack1 === 1'b1) begin order.push_back(1); at.push_back(i); end
      end
      n_total++;
      if (order.size() < 8) begin
         n_bad++; $display("FAIL contend_count got=%0d want>=8", order.size());
      end else begin
         for (int k = 0; k < 8; k++) begin
            n_total++;
            if (order[k] != (k % 2) || at[k] != 2 * k + 1) begin
               n_bad++; $display("FAIL contend_grant k=%0d got id=%0d cyc=%0d want id=%0d cyc=%0d",
                  k, order[k], at[k], k % 2, 2 * k + 1);
            end
         end
      end
      drain();
   endtask

   task automatic test_boundary();
      logic [DW-1:0] got[$];
      q1.push_back(mk(1'b1, 7'h7F, 32'hFFFFFFFF));
      q1.push_back(mk(1'b1, 7'h00, 32'h00000001));
      q1.push_back(mk(1'b0, 7'h7F, 32'h0));
      q1.push_back(mk(1'b0, 7'h00, 32'h0));
      for (int i = 0; i < 10; i++) begin
         step();
         n_total++;
         if ({ack0, ack1, rvalid0, rvalid1, ram_we} !== {exp_ack0, exp_ack1, m_rv0, m_rv1, exp_we}) begin
            n_bad++; $display("FAIL bound_ctl cyc=%0d got=%b want=%b", i,
               {ack0, ack1, rvalid0, rvalid1, ram_we}, {exp_ack0, exp_ack1, m_rv0, m_rv1, exp_we});
         end
         if (rvalid1 === 1'b1) got.push_back(rdata1);
      end
      n_total++;
      if (got.size() != 2 || got[0] !== 32'hFFFFFFFF || got[1] !== 32'h00000001) begin
         n_bad++; $display("FAIL bound_data got n=%0d first=%h want n=2 FFFFFFFF,00000001",
            got.size(), (got.size() > 0) ? got[0] : 32'h0);
      end
      drain();
   endtask

   task automatic test_cross_order();
      bit            rv0_seen = 1'b0;
      logic [DW-1:0] rd1      = '0;
      q0.push_back(mk(1'b1, 7'h20, 32'hA5A5A5A5));
      step();
      q1.push_back(mk(1'b0, 7'h20, 32'h0));
      for (int i = 1; i < 9; i++) begin
         step();
         n_total++;
         if ({ack0, ack1, rvalid0, rvalid1, ram_we} !== {exp_ack0, exp_ack1, m_rv0, m_rv1, exp_we}) begin
            n_bad++; $display("FAIL cross_ctl cyc=%0d got=%b want=%b", i,
               {ack0, ack1, rvalid0, rvalid1, ram_we}, {exp_ack0, exp_ack1, m_rv0, m_rv1, exp_we});
         end
         if (rvalid0 === 1'b1) rv0_seen = 1'b1;
         if (rvalid1 === 1'b1) rd1 = rdata1;
      end
      n_total++;
      if (rd1 !== 32'hA5A5A5A5) begin
         n_bad++; $display("FAIL cross_data got=%h want=a5a5a5a5", rd1);
      end
      n_total++;
      if (rv0_seen) begin
         n_bad++; $display("FAIL cross_rvalid0 got=1 want=0");
      end
   endtask

   task automatic test_read_hold();
      for (int i = 0; i < 5; i++) begin
         step();
         n_total++;
         if (rdata1 !== 32'hA5A5A5A5 || rdata0 !== m_rd0) begin
            n_bad++; $display("FAIL hold_rdata cyc=%0d got=%h/%h want=%h/a5a5a5a5", i, rdata0, rdata1, m_rd0);
         end
         n_total++;
         if ({rvalid0, rvalid1, ram_we} !== 3'b000) begin
            n_bad++; $display("FAIL hold_ctl cyc=%0d got=%b want=000", i, {rvalid0, rvalid1, ram_we});
         end
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         rst_req = ($urandom_range(0, 49) == 0);
         if (q0.size() == 0 && $urandom_range(0, 2) == 0) q0.push_back(mk_rand());
         if (q1.size() == 0 && $urandom_range(0, 2) != 0) q1.push_back(mk_rand());
         step();
         n_total++;
         if ({ack0, ack1, rvalid0, rvalid1, ram_we} !== {exp_ack0, exp_ack1, m_rv0, m_rv1, exp_we}) begin
            n_bad++; $display("FAIL rand_ctl cyc=%0d got=%b want=%b", i,
               {ack0, ack1, rvalid0, rvalid1, ram_we}, {exp_ack0, exp_ack1, m_rv0, m_rv1, exp_we});
         end
         n_total++;
         if (rdata0 !== m_rd0 || rdata1 !== m_rd1) begin
            n_bad++; $display("FAIL rand_rdata cyc=%0d got=%h/%h want=%h/%h", i, rdata0, rdata1, m_rd0, m_rd1);
         end
         n_total++;
         if (ram_address !== m_addr || ram_d !== m_wdata) begin
            n_bad++; $display("FAIL rand_port cyc=%0d got=%h/%h want=%h/%h", i, ram_address, ram_d, m_addr, m_wdata);
         end
         if (rst_req) begin
            q0.delete();
            q1.delete();
         end
      end
      rst_req = 1'b0;
      drain();
   endtask

   initial begin
      test_reset();
      test_reset_mid_access();
      test_write_read();
      test_contention();
      test_boundary();
      test_cross_order();
      test_read_hold();
      test_random();
      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule : tb_ram_arbiter_2req
`default_nettype wire
